// File: rtl/dcpl_drain_ctrl_pkg.sv
// Shared types for the decouple/drain controller.
package lynxTypes;

   typedef enum logic [1:0] {
      ACTIVE,
      DRAIN,
      WAIT_CMPL,
      DECOUPLED
   } dcpl_state_t;

endpackage

// File: rtl/dcpl_drain_ctrl_chan.sv
// Per-channel tracking: mid-packet flag, outstanding request counter and gating.
module dcpl_chan_track #(
   parameter int unsigned CNT_BITS = 6
) (
   input  logic xclk,
   input  logic xreset,
   input  logic pass_all,
   input  logic drain,
   input  logic s_axis_tvalid,
   output logic s_axis_tready,
   input  logic s_axis_tlast,
   output logic m_axis_tvalid,
   input  logic m_axis_tready,
   input  logic s_req_valid,
   output logic s_req_ready,
   output logic m_req_valid,
   input  logic m_req_ready,
   input  logic s_cmpl,
   output logic mid_pkt,
   output logic cnt_zero
);

   logic [CNT_BITS-1:0] cnt;
   logic                str_en;
   logic                req_en;
   logic                axis_hs;
   logic                cnt_inc;
   logic                cnt_dec;

   // an open packet may finish while draining; a saturated counter blocks requests in any state
   assign str_en  = pass_all | (drain & mid_pkt);
   assign req_en  = pass_all & ~(&cnt);

   assign m_axis_tvalid = s_axis_tvalid & str_en;
   assign s_axis_tready = m_axis_tready & str_en;
   assign m_req_valid   = s_req_valid & req_en;
   assign s_req_ready   = m_req_ready & req_en;

   assign axis_hs  = s_axis_tvalid & m_axis_tready & str_en;
   assign cnt_inc  = s_req_valid & m_req_ready & req_en;
   assign cnt_dec  = s_cmpl & (cnt != '0);
   assign cnt_zero = (cnt == '0);

   always_ff @(posedge xclk or posedge xreset) begin
      if (xreset) begin
         mid_pkt <= 1'b0;
         cnt     <= '0;
      end else begin
         if (axis_hs)
            mid_pkt <= ~s_axis_tlast;
         case ({cnt_inc, cnt_dec})
            2'b10:   cnt <= cnt + 1'b1;
            2'b01:   cnt <= cnt - 1'b1;
            default: cnt <= cnt;
         endcase
      end
   end

endmodule

// File: rtl/dcpl_drain_ctrl.sv
// Decouple controller: drains open stream packets and outstanding DMA requests
// before isolating the dynamic region from the static side.
module dcpl_drain_ctrl
   import lynxTypes::*;
#(
   parameter int unsigned N_CHAN        = 2,
   parameter int unsigned N_SYNC        = 2,
   parameter int unsigned CNT_BITS      = 6,
   parameter int unsigned TMO_BITS      = 16,
   parameter int unsigned AXI_DATA_BITS = 64,
   parameter int unsigned REQ_BITS      = 64
) (
   input  logic                                        xclk,
   input  logic                                        xreset,
   input  logic                                        s_decouple_req,
   output logic                                        m_decouple_ack,
   output logic                                        m_timeout,
   input  logic [N_CHAN-1:0]                           s_axis_tvalid,
   output logic [N_CHAN-1:0]                           s_axis_tready,
   input  logic [N_CHAN-1:0][AXI_DATA_BITS-1:0]        s_axis_tdata,
   input  logic [N_CHAN-1:0][AXI_DATA_BITS/8-1:0]      s_axis_tkeep,
   input  logic [N_CHAN-1:0]                           s_axis_tlast,
   output logic [N_CHAN-1:0]                           m_axis_tvalid,
   input  logic [N_CHAN-1:0]                           m_axis_tready,
   output logic [N_CHAN-1:0][AXI_DATA_BITS-1:0]        m_axis_tdata,
   output logic [N_CHAN-1:0][AXI_DATA_BITS/8-1:0]      m_axis_tkeep,
   output logic [N_CHAN-1:0]                           m_axis_tlast,
   input  logic [N_CHAN-1:0]                           s_req_valid,
   output logic [N_CHAN-1:0]                           s_req_ready,
   input  logic [N_CHAN-1:0][REQ_BITS-1:0]             s_req_data,
   output logic [N_CHAN-1:0]                           m_req_valid,
   input  logic [N_CHAN-1:0]                           m_req_ready,
   output logic [N_CHAN-1:0][REQ_BITS-1:0]             m_req_data,
   input  logic [N_CHAN-1:0]                           s_cmpl
);

   dcpl_state_t         state;
   logic [N_SYNC-1:0]   sync_q;
   logic                req_s;
   logic [TMO_BITS-1:0] tmo_cnt;
   logic [TMO_BITS-1:0] tmo_nxt;
   logic                tmo_last;
   logic [N_CHAN-1:0]   mid_pkt;
   logic [N_CHAN-1:0]   cnt_zero;
   logic                any_mid;
   logic                all_zero;
   logic                pass_all;
   logic                drain;

   assign m_axis_tdata = s_axis_tdata;
   assign m_axis_tkeep = s_axis_tkeep;
   assign m_axis_tlast = s_axis_tlast;
   assign m_req_data   = s_req_data;

   assign req_s    = sync_q[N_SYNC-1];
   assign any_mid  = |mid_pkt;
   assign all_zero = &cnt_zero;
   assign pass_all = (state == ACTIVE);
   assign drain    = (state == DRAIN);
   assign tmo_nxt  = tmo_cnt + 1'b1;
   assign tmo_last = &tmo_nxt;

   for (genvar i = 0; i < N_CHAN; i++) begin : g_chan
      dcpl_chan_track #(.CNT_BITS(CNT_BITS)) u_track (
         .xclk          (xclk),
         .xreset        (xreset),
         .pass_all      (pass_all),
         .drain         (drain),
         .s_axis_tvalid (s_axis_tvalid[i]),
         .s_axis_tready (s_axis_tready[i]),
         .s_axis_tlast  (s_axis_tlast[i]),
         .m_axis_tvalid (m_axis_tvalid[i]),
         .m_axis_tready (m_axis_tready[i]),
         .s_req_valid   (s_req_valid[i]),
         .s_req_ready   (s_req_ready[i]),
         .m_req_valid   (m_req_valid[i]),
         .m_req_ready   (m_req_ready[i]),
         .s_cmpl        (s_cmpl[i]),
         .mid_pkt       (mid_pkt[i]),
         .cnt_zero      (cnt_zero[i])
      );
   end

   always_ff @(posedge xclk or posedge xreset) begin
      if (xreset)
         sync_q <= '0;
      else
         sync_q <= {sync_q[N_SYNC-2:0], s_decouple_req};
   end

   // timeout fires on the cycle the counter reaches all-ones, i.e. 2^TMO_BITS-1 cycles after DRAIN entry
   always_ff @(posedge xclk or posedge xreset) begin
      if (xreset) begin
         state          <= ACTIVE;
         tmo_cnt        <= '0;
         m_decouple_ack <= 1'b0;
         m_timeout      <= 1'b0;
      end else begin
         case (state)
            ACTIVE: begin
               if (req_s) begin
                  state   <= DRAIN;
                  tmo_cnt <= '0;
               end
            end
            DRAIN: begin
               if (!req_s) begin
                  state          <= ACTIVE;
                  m_decouple_ack <= 1'b0;
                  m_timeout      <= 1'b0;
               end else if (tmo_last) begin
                  state          <= DECOUPLED;
                  tmo_cnt        <= tmo_nxt;
                  m_decouple_ack <= 1'b1;
                  m_timeout      <= 1'b1;
               end else begin
                  tmo_cnt <= tmo_nxt;
                  if (!any_mid)
                     state <= WAIT_CMPL;
               end
            end
            WAIT_CMPL: begin
               if (!req_s) begin
                  state          <= ACTIVE;
                  m_decouple_ack <= 1'b0;
                  m_timeout      <= 1'b0;
               end else if (all_zero) begin
                  state          <= DECOUPLED;
                  m_decouple_ack <= 1'b1;
               end else if (tmo_last) begin
                  state          <= DECOUPLED;
                  tmo_cnt        <= tmo_nxt;
                  m_decouple_ack <= 1'b1;
                  m_timeout      <= 1'b1;
               end else begin
                  tmo_cnt <= tmo_nxt;
               end
            end
            DECOUPLED: begin
               if (!req_s) begin
                  state          <= ACTIVE;
                  m_decouple_ack <= 1'b0;
                  m_timeout      <= 1'b0;
               end
            end
            default: begin
               state          <= ACTIVE;
               m_decouple_ack <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_dcpl_drain_ctrl.sv
// Scoreboard bench for dcpl_drain_ctrl: a default-sized instance and a small
// CNT_BITS=2 / TMO_BITS=4 instance share one clock.
module tb_dcpl_drain_ctrl;

   logic xclk;
   logic xreset_a, xreset_b;
   int unsigned n_chk = 0;
   int unsigned n_err = 0;

   logic        a_dreq, a_ack, a_tmo;
   logic [1:0]  a_s_axis_tvalid, a_s_axis_tready, a_s_axis_tlast;
   logic [1:0]  a_m_axis_tvalid, a_m_axis_tready, a_m_axis_tlast;
   logic [1:0][7:0] a_s_axis_tdata, a_m_axis_tdata;
   logic [1:0][0:0] a_s_axis_tkeep, a_m_axis_tkeep;
   logic [1:0]  a_s_req_valid, a_s_req_ready, a_m_req_valid, a_m_req_ready, a_s_cmpl;
   logic [1:0][7:0] a_s_req_data, a_m_req_data;

   logic        b_dreq, b_ack, b_tmo;
   logic [1:0]  b_s_axis_tvalid, b_s_axis_tready, b_s_axis_tlast;
   logic [1:0]  b_m_axis_tvalid, b_m_axis_tready, b_m_axis_tlast;
   logic [1:0][7:0] b_s_axis_tdata, b_m_axis_tdata;
   logic [1:0][0:0] b_s_axis_tkeep, b_m_axis_tkeep;
   logic [1:0]  b_s_req_valid, b_s_req_ready, b_m_req_valid, b_m_req_ready, b_s_cmpl;
   logic [1:0][7:0] b_s_req_data, b_m_req_data;

   logic [8:0] qa_axis0[$];
   logic [8:0] qa_axis1[$];
   logic [7:0] qa_req[$];
   logic [7:0] qb_req[$];

   dcpl_drain_ctrl #(
      .N_CHAN(2), .N_SYNC(2), .CNT_BITS(6), .TMO_BITS(16),
      .AXI_DATA_BITS(8), .REQ_BITS(8)
   ) dut_a (
      .xclk(xclk), .xreset(xreset_a), .s_decouple_req(a_dreq),
      .m_decouple_ack(a_ack), .m_timeout(a_tmo),
      .s_axis_tvalid(a_s_axis_tvalid), .s_axis_tready(a_s_axis_tready),
      .s_axis_tdata(a_s_axis_tdata), .s_axis_tkeep(a_s_axis_tkeep), .s_axis_tlast(a_s_axis_tlast),
      .m_axis_tvalid(a_m_axis_tvalid), .m_axis_tready(a_m_axis_tready),
      .m_axis_tdata(a_m_axis_tdata), .m_axis_tkeep(a_m_axis_tkeep), .m_axis_tlast(a_m_axis_tlast),
      .s_req_valid(a_s_req_valid), .s_req_ready(a_s_req_ready), .s_req_data(a_s_req_data),
      .m_req_valid(a_m_req_valid), .m_req_ready(a_m_req_ready), .m_req_data(a_m_req_data),
      .s_cmpl(a_s_cmpl)
   );

   dcpl_drain_ctrl #(
      .N_CHAN(2), .N_SYNC(2), .CNT_BITS(2), .TMO_BITS(4),
      .AXI_DATA_BITS(8), .REQ_BITS(8)
   ) dut_b (
      .xclk(xclk), .xreset(xreset_b), .s_decouple_req(b_dreq),
      .m_decouple_ack(b_ack), .m_timeout(b_tmo),
      .s_axis_tvalid(b_s_axis_tvalid), .s_axis_tready(b_s_axis_tready),
      .s_axis_tdata(b_s_axis_tdata), .s_axis_tkeep(b_s_axis_tkeep), .s_axis_tlast(b_s_axis_tlast),
      .m_axis_tvalid(b_m_axis_tvalid), .m_axis_tready(b_m_axis_tready),
      .m_axis_tdata(b_m_axis_tdata), .m_axis_tkeep(b_m_axis_tkeep), .m_axis_tlast(b_m_axis_tlast),
      .s_req_valid(b_s_req_valid), .s_req_ready(b_s_req_ready), .s_req_data(b_s_req_data),
      .m_req_valid(b_m_req_valid), .m_req_ready(b_m_req_ready), .m_req_data(b_m_req_data),
      .s_cmpl(b_s_cmpl)
   );

   initial xclk = 1'b0;
   always #5 xclk = ~xclk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge xclk);
      #1;
   endtask

   // scoreboard monitors: every handshake on the static side must match the next queued item
   always @(negedge xclk) begin
      if (a_m_axis_tvalid[0] && a_m_axis_tready[0]) begin
         if (qa_axis0.size() == 0) chk("a_axis0_unexpected", 1, 0);
         else chk("a_axis0_beat", {a_m_axis_tlast[0], a_m_axis_tdata[0]}, qa_axis0.pop_front());
      end
      if (a_m_axis_tvalid[1] && a_m_axis_tready[1]) begin
         if (qa_axis1.size() == 0) chk("a_axis1_unexpected", 1, 0);
         else chk("a_axis1_beat", {a_m_axis_tlast[1], a_m_axis_tdata[1]}, qa_axis1.pop_front());
      end
      if (a_m_req_valid[0] && a_m_req_ready[0]) begin
         if (qa_req.size() == 0) chk("a_req_unexpected", 1, 0);
         else chk("a_req_data", a_m_req_data[0], qa_req.pop_front());
      end
      if (b_m_req_valid[0] && b_m_req_ready[0]) begin
         if (qb_req.size() == 0) chk("b_req_unexpected", 1, 0);
         else chk("b_req_data", b_m_req_data[0], qb_req.pop_front());
      end
   end

   task automatic a_req(input logic [7:0] d);
      a_s_req_valid[0] = 1'b1;
      a_s_req_data[0]  = d;
      qa_req.push_back(d);
      tick();
      a_s_req_valid[0] = 1'b0;
   endtask

   task automatic b_req(input logic [7:0] d);
      b_s_req_valid[0] = 1'b1;
      b_s_req_data[0]  = d;
      qb_req.push_back(d);
      tick();
      b_s_req_valid[0] = 1'b0;
   endtask

   task automatic a_cmpl();
      a_s_cmpl[0] = 1'b1;
      tick();
      a_s_cmpl[0] = 1'b0;
   endtask

   task automatic b_cmpl();
      b_s_cmpl[0] = 1'b1;
      tick();
      b_s_cmpl[0] = 1'b0;
   endtask

   task automatic a_beat1(input logic [7:0] d, input logic last);
      a_s_axis_tvalid[1] = 1'b1;
      a_s_axis_tdata[1]  = d;
      a_s_axis_tlast[1]  = last;
      qa_axis1.push_back({last, d});
      tick();
      a_s_axis_tvalid[1] = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      xreset_a = 1'b1; xreset_b = 1'b1;
      a_dreq = 0; a_s_axis_tvalid = '0; a_s_axis_tlast = '0; a_s_axis_tdata = '0; a_s_axis_tkeep = '1;
      a_m_axis_tready = '1; a_s_req_valid = '0; a_s_req_data = '0; a_m_req_ready = '1; a_s_cmpl = '0;
      b_dreq = 0; b_s_axis_tvalid = '0; b_s_axis_tlast = '0; b_s_axis_tdata = '0; b_s_axis_tkeep = '1;
      b_m_axis_tready = '1; b_s_req_valid = '0; b_s_req_data = '0; b_m_req_ready = '1; b_s_cmpl = '0;
      repeat (3) tick();
      xreset_a = 1'b0; xreset_b = 1'b0;
      tick();
      @(negedge xclk);
      chk("rst_ack_a", a_ack, 0);
      chk("rst_tmo_a", a_tmo, 0);
      chk("rst_cnt_a", dut_a.g_chan[0].u_track.cnt, 0);
      chk("rst_ack_b", b_ack, 0);
      tick();

      // drain with an open packet on ch1 and two requests still outstanding on ch0
      a_req(8'h01); a_req(8'h02); a_req(8'h03);
      a_cmpl();
      @(negedge xclk);
      chk("cnt_after_3req_1cmpl", dut_a.g_chan[0].u_track.cnt, 2);
      tick();
      a_beat1(8'h10, 1'b0);
      a_beat1(8'h11, 1'b0);
      a_dreq = 1'b1;
      repeat (5) tick();
      a_s_req_valid[0] = 1'b1;
      a_s_req_data[0]  = 8'hEE;
      @(negedge xclk);
      chk("drain_req_valid_blk", a_m_req_valid[0], 0);
      chk("drain_req_ready_blk", a_s_req_ready[0], 0);
      tick();
      a_s_req_valid[0] = 1'b0;
      a_beat1(8'h12, 1'b0);
      a_beat1(8'h13, 1'b1);
      a_s_axis_tvalid[1] = 1'b1;
      a_s_axis_tdata[1]  = 8'h20;
      a_s_axis_tlast[1]  = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge xclk);
         chk("newpkt_valid_blk", a_m_axis_tvalid[1], 0);
         chk("newpkt_ready_blk", a_s_axis_tready[1], 0);
         tick();
      end
      @(negedge xclk);
      chk("ack_wait_cnt2", a_ack, 0);
      a_cmpl();
      @(negedge xclk);
      chk("ack_wait_cnt1", a_ack, 0);
      a_cmpl();
      @(negedge xclk);
      chk("ack_cnt0_same_cycle", a_ack, 0);
      tick();
      a_s_req_valid[0] = 1'b1;
      @(negedge xclk);
      chk("ack_decoupled", a_ack, 1);
      chk("tmo_normal_drain", a_tmo, 0);
      chk("dec_axis_valid", a_m_axis_tvalid[1], 0);
      chk("dec_axis_ready", a_s_axis_tready[1], 0);
      chk("dec_req_valid", a_m_req_valid[0], 0);
      chk("dec_req_ready", a_s_req_ready[0], 0);
      a_s_axis_tvalid[1] = 1'b0;
      a_s_req_valid[0] = 1'b0;
      a_dreq = 1'b0;
      tick(); tick();
      @(negedge xclk);
      chk("ack_hold_sync", a_ack, 1);
      tick();
      @(negedge xclk);
      chk("ack_recouple", a_ack, 0);
      tick();

      // simultaneous request and completion leave the counter unchanged
      for (int i = 0; i < 5; i++) a_req(8'h30 + 8'(i));
      @(negedge xclk);
      chk("cnt5", dut_a.g_chan[0].u_track.cnt, 5);
      tick();
      a_s_req_valid[0] = 1'b1;
      a_s_req_data[0]  = 8'h35;
      qa_req.push_back(8'h35);
      a_s_cmpl[0] = 1'b1;
      tick();
      a_s_req_valid[0] = 1'b0;
      a_s_cmpl[0] = 1'b0;
      @(negedge xclk);
      chk("cnt5_inc_dec", dut_a.g_chan[0].u_track.cnt, 5);
      tick();
      for (int i = 0; i < 6; i++) a_cmpl();
      @(negedge xclk);
      chk("cnt0_extra_cmpl", dut_a.g_chan[0].u_track.cnt, 0);
      tick();

      // abort from WAIT_CMPL
      a_req(8'h40);
      a_dreq = 1'b1;
      repeat (5) tick();
      a_dreq = 1'b0;
      a_s_axis_tvalid[0] = 1'b1;
      a_s_axis_tdata[0]  = 8'h41;
      a_s_axis_tlast[0]  = 1'b1;
      tick();
      @(negedge xclk);
      chk("abort_blk1", a_m_axis_tvalid[0], 0);
      tick();
      @(negedge xclk);
      chk("abort_blk2", a_m_axis_tvalid[0], 0);
      qa_axis0.push_back({1'b1, 8'h41});
      tick();
      @(negedge xclk);
      chk("abort_pass", a_m_axis_tvalid[0], 1);
      chk("abort_tmo", a_tmo, 0);
      chk("abort_ack", a_ack, 0);
      tick();
      a_s_axis_tvalid[0] = 1'b0;
      a_cmpl();

      // reset pulse while draining
      a_req(8'h50); a_req(8'h51);
      a_dreq = 1'b1;
      repeat (3) tick();
      a_dreq = 1'b0;
      xreset_a = 1'b1;
      #2;
      xreset_a = 1'b0;
      a_s_req_valid[0] = 1'b1;
      a_s_req_data[0]  = 8'h52;
      qa_req.push_back(8'h52);
      @(negedge xclk);
      chk("rstd_ack", a_ack, 0);
      chk("rstd_cnt0", dut_a.g_chan[0].u_track.cnt, 0);
      chk("rstd_pass", a_m_req_valid[0], 1);
      tick();
      a_s_req_valid[0] = 1'b0;

      // small instance: saturated counter blocks requests
      b_req(8'h60); b_req(8'h61); b_req(8'h62);
      b_s_req_valid[0] = 1'b1;
      b_s_req_data[0]  = 8'h63;
      for (int i = 0; i < 2; i++) begin
         @(negedge xclk);
         chk("sat_ready_blk", b_s_req_ready[0], 0);
         chk("sat_valid_blk", b_m_req_valid[0], 0);
         tick();
      end
      b_s_cmpl[0] = 1'b1;
      @(negedge xclk);
      chk("sat_ready_cmpl_cycle", b_s_req_ready[0], 0);
      tick();
      b_s_cmpl[0] = 1'b0;
      qb_req.push_back(8'h63);
      @(negedge xclk);
      chk("sat_ready_after_cmpl", b_s_req_ready[0], 1);
      tick();
      b_s_req_valid[0] = 1'b0;
      b_cmpl(); b_cmpl();

      // timeout with one request outstanding
      b_dreq = 1'b1;
      repeat (17) tick();
      @(negedge xclk);
      chk("tmo_ack_early", b_ack, 0);
      chk("tmo_flag_early", b_tmo, 0);
      tick();
      @(negedge xclk);
      chk("tmo_ack", b_ack, 1);
      chk("tmo_flag", b_tmo, 1);
      chk("tmo_cnt_kept", dut_b.g_chan[0].u_track.cnt, 1);
      b_dreq = 1'b0;
      repeat (3) tick();
      @(negedge xclk);
      chk("tmo_clear_active", b_tmo, 0);
      chk("tmo_ack_clear", b_ack, 0);
      tick();

      chk("qa_axis0_empty", qa_axis0.size(), 0);
      chk("qa_axis1_empty", qa_axis1.size(), 0);
      chk("qa_req_empty", qa_req.size(), 0);
      chk("qb_req_empty", qb_req.size(), 0);
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
